// File: rtl/linear_layer_start_fifo_srl_if.sv
// Start-token FIFO handshake bundle. The write side connects to the upstream task and the
// read side connects to the downstream PE task.
interface linear_layer_start_fifo_srl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
);
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic [ADDR_WIDTH:0]   if_num_data_valid;

  modport slave (
    output if_full_n, if_empty_n, if_dout, if_num_data_valid,
    input  if_write_ce, if_write, if_din, if_read_ce, if_read
  );

  modport master (
    input  if_full_n, if_empty_n, if_dout, if_num_data_valid,
    output if_write_ce, if_write, if_din, if_read_ce, if_read
  );
endinterface

// File: rtl/linear_layer_start_fifo_srl.sv
// SRL-style start-token FIFO: shift-in at entry 0, head read at entry cnt-1, first-word-fall-through.
// Occupancy and flags are registered. The storage array is deliberately left out of reset.
module linear_layer_start_fifo_srl_cell #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (en) q <= d;
endmodule

module linear_layer_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input logic                          clk,
  input logic                          reset,
  linear_layer_start_fifo_srl_if.slave fifo
);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] arr;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             empty_n_q, empty_n_d;
  logic                             full_n_q, full_n_d;
  logic                             push, pop, shift_en;
  logic [ADDR_WIDTH-1:0]            rd_idx;

  assign push     = fifo.if_write_ce & fifo.if_write & full_n_q;
  assign pop      = fifo.if_read_ce & fifo.if_read & empty_n_q;
  // A push that arrives in the reset cycle is dropped, so the array must not shift either.
  assign shift_en = push & ~reset;

  for (genvar g = 0; g < DEPTH; g++) begin : g_srl
    if (g == 0) begin : g_head
      linear_layer_start_fifo_srl_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
        .clk(clk), .en(shift_en), .d(fifo.if_din), .q(arr[g])
      );
    end else begin : g_tail
      linear_layer_start_fifo_srl_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
        .clk(clk), .en(shift_en), .d(arr[g-1]), .q(arr[g])
      );
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    empty_n_d = empty_n_q;
    full_n_d  = full_n_q;
    if (push && !pop) begin
      cnt_d     = cnt_q + ONE;
      empty_n_d = 1'b1;
      full_n_d  = (cnt_q + ONE) != DEPTH_C;
    end else if (pop && !push) begin
      cnt_d     = cnt_q - ONE;
      full_n_d  = 1'b1;
      empty_n_d = (cnt_q - ONE) != '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  // Head sits at the oldest occupied entry; simultaneous push+pop shifts the next entry into it.
  assign rd_idx = (cnt_q == '0) ? '0 : ADDR_WIDTH'(cnt_q - ONE);

  assign fifo.if_dout           = arr[rd_idx];
  assign fifo.if_empty_n        = empty_n_q;
  assign fifo.if_full_n         = full_n_q;
  assign fifo.if_num_data_valid = cnt_q;
endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Bench for the start-token FIFO: queue reference model checked every cycle plus directed literal checks.
module tb_linear_layer_start_fifo_srl;
  localparam int DW = 8;
  localparam int AW = 1;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  linear_layer_start_fifo_srl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fifo ();

  linear_layer_start_fifo_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .fifo(fifo)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue bounded by DEPTH.
  always @(posedge clk) begin
    if (reset) q.delete();
    else begin
      bit p, o;
      p = fifo.if_write_ce && fifo.if_write && (q.size() < DEPTH);
      o = fifo.if_read_ce && fifo.if_read && (q.size() > 0);
      if (o) void'(q.pop_front());
      if (p) q.push_back(fifo.if_din);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty_n", int'(fifo.if_empty_n), int'(q.size() != 0));
      chk("full_n", int'(fifo.if_full_n), int'(q.size() != DEPTH));
      chk("num", int'(fifo.if_num_data_valid), q.size());
      if (q.size() != 0) chk("dout", int'(fifo.if_dout), int'(q[0]));
    end
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic wce = 1'b1, input logic rce = 1'b1);
    fifo.if_write = w; fifo.if_din = d; fifo.if_read = r;
    fifo.if_write_ce = wce; fifo.if_read_ce = rce;
    @(negedge clk); #1;
    fifo.if_write = 1'b0; fifo.if_read = 1'b0;
    fifo.if_write_ce = 1'b1; fifo.if_read_ce = 1'b1;
  endtask

  initial begin
    fifo.if_write = 1'b0; fifo.if_read = 1'b0; fifo.if_din = '0;
    fifo.if_write_ce = 1'b1; fifo.if_read_ce = 1'b1;
    reset = 1'b1;
    @(negedge clk); #1;
    chk_en = 1'b1;
    cyc(0, 8'h00, 0); cyc(0, 8'h00, 0);
    reset = 1'b0;
    chk("rst_empty_n", int'(fifo.if_empty_n), 0);
    chk("rst_full_n", int'(fifo.if_full_n), 1);
    chk("rst_num", int'(fifo.if_num_data_valid), 0);

    // Single push latency
    cyc(1, 8'hA5, 0);
    chk("push_empty_n", int'(fifo.if_empty_n), 1);
    chk("push_dout", int'(fifo.if_dout), 'hA5);
    chk("push_num", int'(fifo.if_num_data_valid), 1);
    chk("push_full_n", int'(fifo.if_full_n), 1);
    cyc(0, 8'h00, 1);
    chk("pop_empty", int'(fifo.if_empty_n), 0);

    // Fill, overflow attempt, drain
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 0);
    chk("full_full_n", int'(fifo.if_full_n), 0);
    chk("full_num", int'(fifo.if_num_data_valid), 2);
    cyc(1, 8'h33, 0);
    chk("ovf_num", int'(fifo.if_num_data_valid), 2);
    chk("ovf_dout", int'(fifo.if_dout), 'h11);
    cyc(0, 8'h00, 1);
    chk("drain1_dout", int'(fifo.if_dout), 'h22);
    chk("drain1_full_n", int'(fifo.if_full_n), 1);
    cyc(0, 8'h00, 1);
    chk("drain2_empty_n", int'(fifo.if_empty_n), 0);
    chk("drain2_full_n", int'(fifo.if_full_n), 1);
    cyc(0, 8'h00, 1);
    chk("underflow_num", int'(fifo.if_num_data_valid), 0);

    // Simultaneous push+pop at occupancy 1
    cyc(1, 8'h11, 0);
    cyc(1, 8'h22, 1);
    chk("pp_num", int'(fifo.if_num_data_valid), 1);
    chk("pp_dout", int'(fifo.if_dout), 'h22);

    // Clock-enables low suppress both ports
    cyc(0, 8'h00, 1, 1'b1, 1'b0);
    chk("rce_num", int'(fifo.if_num_data_valid), 1);
    cyc(1, 8'h77, 0, 1'b0, 1'b1);
    chk("wce_num", int'(fifo.if_num_data_valid), 1);
    chk("wce_dout", int'(fifo.if_dout), 'h22);

    // Reset while full with a push in the same cycle
    cyc(1, 8'h33, 0);
    chk("pre_rst_num", int'(fifo.if_num_data_valid), 2);
    reset = 1'b1;
    cyc(1, 8'h44, 0);
    reset = 1'b0;
    chk("mid_rst_empty_n", int'(fifo.if_empty_n), 0);
    chk("mid_rst_full_n", int'(fifo.if_full_n), 1);
    chk("mid_rst_num", int'(fifo.if_num_data_valid), 0);

    // Mixed traffic checked against the model
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0));
    cyc(0, 8'h00, 1); cyc(0, 8'h00, 1); cyc(0, 8'h00, 1);
    chk("final_empty_n", int'(fifo.if_empty_n), 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
